abm_stream_loader: RTL and testbench
====================================

// Module: abm_stream_loader
// PURPOSE
//   Receives one ABM frame (ENTRIES words) over AXI-Stream and writes it into the
//   inactive half of a ping-pong ABM RAM. Only a complete, correctly sized frame
//   flips the active bank and pulses abm_updated. One instance per ABM block feeds
//   abm0_updated / abm1_updated of the downstream ABM-ready notifier.
// PARAMETERS
//   DW       32    stream / RAM data width, bits
//   ENTRIES  1024  words per ABM frame, >= 2
//   AW       10    entry-index width, must equal clog2(ENTRIES)
//   CW       16    width of the good/short/long frame counters
// PORTS
//   clk           in   1       single clock; all logic on its rising edge
//   resetn        in   1       asynchronous, active-low reset
//   axis_tdata    in   DW      frame word
//   axis_tvalid   in   1       beat valid
//   axis_tlast    in   1       last beat of frame
//   axis_tready   out  1       1 whenever resetn=1; this block never back-pressures
//   ram_we        out  1       RAM write strobe
//   ram_waddr     out  AW+1    {bank, index}; bank = ~active_bank
//   ram_wdata     out  DW      RAM write data
//   active_bank   out  1       bank readers use; toggles only on a good frame
//   abm_updated   out  1       1-cycle pulse when a good frame is committed
//   short_err     out  1       1-cycle pulse: tlast seen before ENTRIES beats
//   long_err      out  1       1-cycle pulse: ENTRIES beats seen without tlast
//   good_count    out  CW      good frames committed; wraps to 0 at 2^CW
//   err_count     out  CW      short + long errors; saturates at 2^CW-1
// BEHAVIOUR
//   - Reset (async assert, sync release): every output 0, index=0, state RECV.
//     Reset mid-frame discards the partial frame; the RAM is not cleared.
//   - Beat accepted when tvalid & tready. Beat accepted in cycle N -> ram_we=1 with
//     ram_waddr={~active_bank, index}, ram_wdata=tdata at N+1 (registered).
//   - FSM states RECV, DRAIN.
//     RECV, beat accepted:
//       tlast & index==ENTRIES-1  -> good frame: index=0; at N+2 abm_updated=1,
//                                    active_bank toggles, good_count+1.
//       tlast & index< ENTRIES-1  -> short frame: index=0; short_err=1 at N+1;
//                                    the written words stay in the inactive bank.
//       ~tlast & index==ENTRIES-1 -> long frame: index=0; long_err=1 at N+1; go DRAIN.
//       otherwise                 -> index+1.
//     DRAIN: no RAM writes; accepted beats are discarded; the beat carrying tlast
//       returns the FSM to RECV. The next beat starts a new frame.
//   - The commit at N+2 comes after the frame's final write at N+1. Because of
//     this ordering, readers never see a torn bank.
//   - Back-to-back frames: the first beat of the next frame may be accepted at N+1.
//     Its write at N+2 uses the pre-toggle bank value; the new frame goes to the
//     bank that was active until N+2. This is correct: that bank becomes inactive at
//     N+2. The index-to-bank mapping must use the bank value registered with the beat.
//     Simpler equivalent: latch the target bank at frame start.
//   - tvalid=0 cycles anywhere in a frame are legal and add no state change.
//   - ENTRIES=1: not supported (parameter check via generate-time $error).
//   - Only one of abm_updated / short_err / long_err pulses for any frame.
// STRUCTURE
//   - Shared header abm_defs.vh: ABM_ENTRIES, ABM_AW, ABM_DW, and the FSM state
//     encodings ABM_LD_RECV=1'b0 and ABM_LD_DRAIN=1'b1. The notifier and the readers
//     use the same header.
//   - Single module; no sub-module. The RAM is external and instantiated by the parent.
// TESTING (ENTRIES=8, DW=32, CW=16)
//   1. Frame of 8 beats, data 0..7, tlast on beat 8 -> writes addr 8..15 with data
//      0..7; abm_updated pulse 2 cycles after beat 8; active_bank 0->1; good_count=1.
//   2. Two frames back to back, no gaps -> second frame writes addr 0..7;
//      active_bank returns to 0; two abm_updated pulses 8 cycles apart.
//   3. 5 beats with tlast on beat 5 -> short_err once; no abm_updated;
//      active_bank unchanged; err_count=1. Next 8-beat frame commits normally.
//   4. 11 beats, tlast on beat 11 -> 8 writes; long_err after beat 8; beats 9-11
//      discarded; no commit. The next frame is good.
//   5. resetn low for 1 cycle after beat 4 of a frame -> all outputs 0 immediately.
//      A following 8-beat frame commits to bank 1 with good_count=1.
//   6. Random tvalid gaps within 100 good frames -> good_count=100; active_bank=0.
//      A scoreboard confirms the committed bank contents match each frame.

Source files
------------

// File: rtl/abm_stream_loader_pkg.sv
// Shared definitions for the ABM stream loader and its neighbours.
//   ABM_*        default frame geometry, shared by the loader, notifier and readers
//   abm_ld_state_e  loader FSM states: StRecv writes beats, StDrain discards the
//                   tail of an over-long frame
package abm_stream_loader_pkg;

   localparam int unsigned ABM_DW      = 32;
   localparam int unsigned ABM_ENTRIES = 1024;
   localparam int unsigned ABM_AW      = 10;
   localparam int unsigned ABM_CW      = 16;

   typedef enum logic {
      StRecv  = 1'b0,
      StDrain = 1'b1
   } abm_ld_state_e;

endpackage

// File: rtl/abm_stream_loader.sv
// Receives one ABM frame of ENTRIES words over AXI-Stream and writes it into the
// inactive half of an external ping-pong ABM RAM. Only a complete, correctly sized
// frame flips active_bank and pulses abm_updated.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   axis_tdata/tvalid/tlast     frame beats in
//   axis_tready                 follows resetn; the loader never back-pressures
//   ram_we/ram_waddr/ram_wdata  registered RAM write port, waddr = {bank, index}
//   active_bank                 bank the readers use
//   abm_updated                 1-cycle pulse when a good frame is committed
//   short_err / long_err        1-cycle pulses for frames with too few / too many beats
//   good_count                  committed frames, wrapping
//   err_count                   short + long errors, saturating
module abm_stream_loader
   import abm_stream_loader_pkg::*;
#(
   parameter int unsigned DW      = ABM_DW,
   parameter int unsigned ENTRIES = ABM_ENTRIES,
   parameter int unsigned AW      = ABM_AW,
   parameter int unsigned CW      = ABM_CW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [DW-1:0] axis_tdata,
   input  logic          axis_tvalid,
   input  logic          axis_tlast,
   output logic          axis_tready,
   output logic          ram_we,
   output logic [AW:0]   ram_waddr,
   output logic [DW-1:0] ram_wdata,
   output logic          active_bank,
   output logic          abm_updated,
   output logic          short_err,
   output logic          long_err,
   output logic [CW-1:0] good_count,
   output logic [CW-1:0] err_count
);

   if (ENTRIES < 2) begin : g_bad_entries
      $error("abm_stream_loader: ENTRIES must be at least 2");
   end
   if (AW != $clog2(ENTRIES)) begin : g_bad_aw
      $error("abm_stream_loader: AW must equal clog2(ENTRIES)");
   end

   localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

   abm_ld_state_e state_q;
   logic [AW-1:0] index_q;
   // Bank the current frame is written to. It flips as soon as a good frame's last
   // beat is accepted, one cycle before active_bank does, so a back-to-back next
   // frame already targets the bank that is about to become inactive.
   logic          wr_bank_q;
   // A good frame's last beat was accepted last cycle; commit once its write lands.
   logic          commit_q;

   logic beat;
   logic at_last;

   assign axis_tready = resetn;
   assign beat        = axis_tvalid & axis_tready;
   assign at_last     = (index_q == LAST_IDX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StRecv;
         index_q     <= '0;
         wr_bank_q   <= 1'b1;
         commit_q    <= 1'b0;
         ram_we      <= 1'b0;
         ram_waddr   <= '0;
         ram_wdata   <= '0;
         active_bank <= 1'b0;
         abm_updated <= 1'b0;
         short_err   <= 1'b0;
         long_err    <= 1'b0;
         good_count  <= '0;
         err_count   <= '0;
      end else begin
         ram_we      <= 1'b0;
         abm_updated <= 1'b0;
         short_err   <= 1'b0;
         long_err    <= 1'b0;
         commit_q    <= 1'b0;

         if (commit_q) begin
            active_bank <= ~active_bank;
            abm_updated <= 1'b1;
            good_count  <= good_count + 1'b1;
         end

         if (beat) begin
            unique case (state_q)
               StRecv: begin
                  ram_we    <= 1'b1;
                  ram_waddr <= {wr_bank_q, index_q};
                  ram_wdata <= axis_tdata;
                  if (axis_tlast && at_last) begin
                     index_q   <= '0;
                     commit_q  <= 1'b1;
                     wr_bank_q <= ~wr_bank_q;
                  end else if (axis_tlast) begin
                     index_q   <= '0;
                     short_err <= 1'b1;
                     if (err_count != {CW{1'b1}}) err_count <= err_count + 1'b1;
                  end else if (at_last) begin
                     index_q  <= '0;
                     long_err <= 1'b1;
                     if (err_count != {CW{1'b1}}) err_count <= err_count + 1'b1;
                     state_q  <= StDrain;
                  end else begin
                     index_q <= index_q + 1'b1;
                  end
               end
               StDrain: begin
                  if (axis_tlast) state_q <= StRecv;
               end
               default: state_q <= StRecv;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_abm_stream_loader.sv
module tb_abm_stream_loader;

   localparam int ENT = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] axis_tdata;
   logic        axis_tvalid;
   logic        axis_tlast;
   logic        axis_tready;
   logic        ram_we;
   logic [3:0]  ram_waddr;
   logic [31:0] ram_wdata;
   logic        active_bank;
   logic        abm_updated;
   logic        short_err;
   logic        long_err;
   logic [15:0] good_count;
   logic [15:0] err_count;

   abm_stream_loader #(
      .DW(32), .ENTRIES(ENT), .AW(3), .CW(16)
   ) dut (
      .clk(clk), .resetn(resetn),
      .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
      .axis_tready(axis_tready),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .active_bank(active_bank), .abm_updated(abm_updated),
      .short_err(short_err), .long_err(long_err),
      .good_count(good_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Shadow RAM and event log, sampled on the falling edge.
   logic [31:0] mem [0:15];
   int          wr_cnt = 0, upd_cnt = 0, short_cnt = 0, long_cnt = 0;
   time         upd_t [0:255];
   time         wr_last_t = 0, short_t = 0, long_t = 0;
   time         beat_t [0:15];

   always @(negedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
         wr_cnt         <= wr_cnt + 1;
         wr_last_t      <= $time;
      end
      if (abm_updated) begin
         upd_t[upd_cnt & 255] <= $time;
         upd_cnt              <= upd_cnt + 1;
      end
      if (short_err) begin
         short_cnt <= short_cnt + 1;
         short_t   <= $time;
      end
      if (long_err) begin
         long_cnt <= long_cnt + 1;
         long_t   <= $time;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         axis_tvalid = 1'b0;
         axis_tlast  = 1'b0;
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      @(negedge clk);
      axis_tdata  = d;
      axis_tvalid = 1'b1;
      axis_tlast  = l;
   endtask

   // n beats of data base+i; tlast on beat n when with_last; optional random gaps.
   task automatic frame(input int n, input int base, input bit with_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) idle(1);
         end
         beat(32'(base + i), with_last && (i == n - 1));
         beat_t[i & 15] = $time;
      end
   endtask

   task automatic chk_bank(input string tag, input int bank, input int n, input int base);
      for (int i = 0; i < n; i++) chk(tag, mem[bank * ENT + i], 64'(base + i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      axis_tvalid = 1'b0;
      axis_tlast  = 1'b0;
      resetn      = 1'b0;
      #1;
      chk("rst outs a", {ram_we, ram_waddr, ram_wdata, active_bank, abm_updated},
          64'd0);
      chk("rst outs b", {short_err, long_err, good_count, err_count, axis_tready}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   int  exp_active;
   int  u0, w0, s0, l0, ok;

   initial begin
      resetn      = 1'b0;
      axis_tdata  = '0;
      axis_tvalid = 1'b0;
      axis_tlast  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset outs a", {ram_we, ram_waddr, ram_wdata, active_bank, abm_updated}, 64'd0);
      chk("reset outs b", {short_err, long_err, good_count, err_count, axis_tready}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("tready after reset", axis_tready, 1);
      exp_active = 0;

      // 1: single good frame goes to bank 1
      u0 = upd_cnt; w0 = wr_cnt;
      frame(8, 0, 1, 0);
      idle(4);
      chk("t1 writes", wr_cnt - w0, 8);
      chk("t1 last write time", wr_last_t, beat_t[7] + 10);
      chk("t1 upd pulses", upd_cnt - u0, 1);
      chk("t1 upd time", upd_t[u0], beat_t[7] + 20);
      chk_bank("t1 word", 1, 8, 0);
      chk("t1 active_bank", active_bank, 1);
      chk("t1 good_count", good_count, 1);
      exp_active = 1;

      // 2: two frames back to back, no gap between them
      u0 = upd_cnt;
      frame(8, 100, 1, 0);
      frame(8, 200, 1, 0);
      idle(4);
      chk("t2 upd pulses", upd_cnt - u0, 2);
      chk("t2 upd spacing", upd_t[u0 + 1] - upd_t[u0], 80);
      chk_bank("t2 first word", 0, 8, 100);
      chk_bank("t2 second word", 1, 8, 200);
      chk("t2 active_bank", active_bank, 1);
      chk("t2 good_count", good_count, 3);

      // 3: short frame of 5 beats lands in bank 0, no commit
      u0 = upd_cnt; s0 = short_cnt;
      frame(5, 300, 1, 0);
      idle(4);
      chk("t3 short pulses", short_cnt - s0, 1);
      chk("t3 short time", short_t, beat_t[4] + 10);
      chk("t3 no upd", upd_cnt - u0, 0);
      chk("t3 active_bank", active_bank, 1);
      chk("t3 err_count", err_count, 1);
      chk_bank("t3 word", 0, 5, 300);
      frame(8, 400, 1, 0);
      idle(4);
      chk_bank("t3 next word", 0, 8, 400);
      chk("t3 next active", active_bank, 0);
      chk("t3 next good", good_count, 4);

      // 4: 11-beat frame, only the first 8 are written
      u0 = upd_cnt; w0 = wr_cnt; l0 = long_cnt;
      frame(11, 500, 1, 0);
      idle(4);
      chk("t4 writes", wr_cnt - w0, 8);
      chk("t4 long pulses", long_cnt - l0, 1);
      chk("t4 long time", long_t, beat_t[7] + 10);
      chk("t4 no upd", upd_cnt - u0, 0);
      chk("t4 err_count", err_count, 2);
      chk("t4 active_bank", active_bank, 0);
      chk_bank("t4 word", 1, 8, 500);
      frame(8, 600, 1, 0);
      idle(4);
      chk_bank("t4 next word", 1, 8, 600);
      chk("t4 next active", active_bank, 1);
      chk("t4 next good", good_count, 5);

      // 5: reset after beat 4 of a frame
      frame(4, 700, 0, 0);
      do_reset();
      frame(8, 800, 1, 0);
      idle(4);
      chk_bank("t5 word", 1, 8, 800);
      chk("t5 active_bank", active_bank, 1);
      chk("t5 good_count", good_count, 1);
      chk("t5 err_count", err_count, 0);

      // 6: 100 good frames with random tvalid gaps
      do_reset();
      exp_active = 0;
      for (int f = 0; f < 100; f++) begin
         frame(8, 1000 + f * 8, 1, 1);
         idle(2);
         ok = 0;
         for (int i = 0; i < 8; i++)
            if (mem[(1 - exp_active) * ENT + i] === 32'(1000 + f * 8 + i)) ok++;
         chk("t6 frame words", ok, 8);
         exp_active = 1 - exp_active;
      end
      idle(4);
      chk("t6 good_count", good_count, 100);
      chk("t6 active_bank", active_bank, 0);
      chk("t6 err_count", err_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
